// File: rtl/linalg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : linalg_pkg                                                   |
// | Description : Shared types and constants for the linalg block family      |
// |               (vector_gather, inner_product and later blocks).             |
// |               float_t        - IEEE-754 single-precision word              |
// |               gather_state_e - FILL / PRESENT handshake states             |
// |               FLOAT_ZERO     - +0.0 encoding, used as the reset value      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package linalg_pkg;

  typedef logic [31:0] float_t;

  typedef enum logic [0:0] {
    ST_FILL    = 1'b0,
    ST_PRESENT = 1'b1
  } gather_state_e;

  localparam float_t FLOAT_ZERO = 32'h0000_0000;

endpackage : linalg_pkg
`default_nettype wire

// File: rtl/vector_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vector_bank                                                  |
// | Description : One N-lane (a, b) pair register with write-lane counter and  |
// |               full flag. Each write lands in the lane given by the counter;|
// |               the write into lane N-1 wraps the counter and sets full.     |
// |               The bank stays full until released by the owner.             |
// | Ports       : clk, rst (async, active low)                                 |
// |               wr_en, wr_a, wr_b  - write one pair into the current lane    |
// |               rel                - clear the full flag                     |
// |               full, last         - bank full / next write completes it     |
// |               v1, v2             - packed lanes, lane k = bits [W*k +: W]  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vector_bank
  import linalg_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [W-1:0]   wr_a,
  input  logic [W-1:0]   wr_b,
  input  logic           rel,
  output logic           full,
  output logic           last,
  output logic [N*W-1:0] v1,
  output logic [N*W-1:0] v2
);

  // A one-lane bank still needs a 1-bit counter to keep the ranges legal.
  localparam int             IDX_W     = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [W-1:0]   LANE_ZERO = W'(FLOAT_ZERO);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             full_q, full_d;
  logic [N*W-1:0]   v1_q, v1_d;
  logic [N*W-1:0]   v2_q, v2_d;

  always_comb begin
    idx_d  = idx_q;
    full_d = full_q;
    v1_d   = v1_q;
    v2_d   = v2_q;
    if (wr_en) begin
      v1_d[W*int'(idx_q) +: W] = wr_a;
      v2_d[W*int'(idx_q) +: W] = wr_b;
      if (idx_q == LAST_IDX) begin
        idx_d  = '0;
        full_d = 1'b1;
      end else begin
        idx_d  = idx_q + IDX_W'(1);
      end
    end
    // The owner never writes and releases the same bank on one edge.
    if (rel) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= '0;
      full_q <= 1'b0;
      v1_q   <= {N{LANE_ZERO}};
      v2_q   <= {N{LANE_ZERO}};
    end else begin
      idx_q  <= idx_d;
      full_q <= full_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
    end
  end

  assign full = full_q;
  assign last = (idx_q == LAST_IDX);
  assign v1   = v1_q;
  assign v2   = v2_q;

endmodule : vector_bank
`default_nettype wire

// File: rtl/vector_gather.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vector_gather                                                |
// | Description : Deserialises a stream of (a, b) element pairs into two       |
// |               packed N-element vectors for inner_product. Each output      |
// |               vector has its own stb/ack and is released independently.   |
// |               All outputs come straight from flops.                        |
// | Ports       : clk, rst (async, active low)                                 |
// |               input_a/input_b/input_stb/input_ack       - pair stream      |
// |               output_v1/output_v1_stb/output_v1_ack     - vector 1         |
// |               output_v2/output_v2_stb/output_v2_ack     - vector 2         |
// | Config      : VECTOR_GATHER_DBUF_EN - two banks; filling continues while   |
// |               the other bank is presented. Undefined: single bank.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vector_gather
  import linalg_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   input_a,
  input  logic [W-1:0]   input_b,
  input  logic           input_stb,
  output logic           input_ack,
  output logic [N*W-1:0] output_v1,
  output logic [N*W-1:0] output_v2,
  output logic           output_v1_stb,
  output logic           output_v2_stb,
  input  logic           output_v1_ack,
  input  logic           output_v2_ack
);

`ifdef VECTOR_GATHER_DBUF_EN
  localparam int NUM_BANKS = 2;
`else
  localparam int NUM_BANKS = 1;
`endif

  gather_state_e state_q, state_d;
  logic          input_ack_q, input_ack_d;
  logic          v1_stb_q, v1_stb_d;
  logic          v2_stb_q, v2_stb_d;

  logic                 xfer;
  logic                 v1_clr;
  logic                 v2_clr;
  logic                 stbs_clear_next;
  logic [NUM_BANKS-1:0] bank_wr;
  logic [NUM_BANKS-1:0] bank_rel;
  logic [NUM_BANKS-1:0] bank_full;
  logic [NUM_BANKS-1:0] bank_last;
  logic [N*W-1:0]       bank_v1 [NUM_BANKS];
  logic [N*W-1:0]       bank_v2 [NUM_BANKS];

  generate
    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      vector_bank #(
        .N (N),
        .W (W)
      ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .wr_en (bank_wr[g]),
        .wr_a  (input_a),
        .wr_b  (input_b),
        .rel   (bank_rel[g]),
        .full  (bank_full[g]),
        .last  (bank_last[g]),
        .v1    (bank_v1[g]),
        .v2    (bank_v2[g])
      );
    end
  endgenerate

  assign xfer   = input_stb && input_ack_q;
  assign v1_clr = v1_stb_q && output_v1_ack;
  assign v2_clr = v2_stb_q && output_v2_ack;
  // Nothing is presented after this edge: each stb is either already low or
  // being taken now.
  assign stbs_clear_next = (!v1_stb_q || v1_clr) && (!v2_stb_q || v2_clr);

`ifdef VECTOR_GATHER_DBUF_EN
  // fill_sel_q names the bank being filled; the other bank is presented.
  // state_q tracks whether the presented bank still holds an unreleased
  // vector.
  logic fill_sel_q, fill_sel_d;
  logic fill_ready;
  logic swap;

  always_comb begin
    fill_ready = (xfer && bank_last[fill_sel_q]) || bank_full[fill_sel_q];
    // The completed fill bank is handed over as soon as the presented bank
    // frees up, including on the very edge that frees it.
    swap       = fill_ready && stbs_clear_next;

    bank_wr[0]  = xfer && !fill_sel_q && !bank_full[0];
    bank_wr[1]  = xfer &&  fill_sel_q && !bank_full[1];
    bank_rel[0] = fill_sel_q  && (state_q == ST_PRESENT) && stbs_clear_next;
    bank_rel[1] = !fill_sel_q && (state_q == ST_PRESENT) && stbs_clear_next;

    fill_sel_d  = swap ? !fill_sel_q : fill_sel_q;
    v1_stb_d    = (v1_stb_q && !v1_clr) || swap;
    v2_stb_d    = (v2_stb_q && !v2_clr) || swap;
    state_d     = (v1_stb_d || v2_stb_d) ? ST_PRESENT : ST_FILL;
    // After a swap the new fill bank is the one just released, so input
    // only closes when a full fill bank is left waiting.
    input_ack_d = !(fill_ready && !swap);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_sel_q <= 1'b0;
    end else begin
      fill_sel_q <= fill_sel_d;
    end
  end

  assign output_v1 = fill_sel_q ? bank_v1[0] : bank_v1[1];
  assign output_v2 = fill_sel_q ? bank_v2[0] : bank_v2[1];
`else
  always_comb begin
    bank_wr[0]  = xfer && !bank_full[0];
    bank_rel[0] = (state_q == ST_PRESENT) && stbs_clear_next;

    state_d  = state_q;
    v1_stb_d = v1_stb_q && !v1_clr;
    v2_stb_d = v2_stb_q && !v2_clr;
    case (state_q)
      ST_FILL: begin
        if (xfer && bank_last[0]) begin
          state_d  = ST_PRESENT;
          v1_stb_d = 1'b1;
          v2_stb_d = 1'b1;
        end
      end
      ST_PRESENT: begin
        if (stbs_clear_next) begin
          state_d = ST_FILL;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
    input_ack_d = (state_d == ST_FILL);
  end

  assign output_v1 = bank_v1[0];
  assign output_v2 = bank_v2[0];
`endif

  // input_ack resets low and rises on the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_FILL;
      input_ack_q <= 1'b0;
      v1_stb_q    <= 1'b0;
      v2_stb_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      input_ack_q <= input_ack_d;
      v1_stb_q    <= v1_stb_d;
      v2_stb_q    <= v2_stb_d;
    end
  end

  assign input_ack     = input_ack_q;
  assign output_v1_stb = v1_stb_q;
  assign output_v2_stb = v2_stb_q;

endmodule : vector_gather
`default_nettype wire

// File: tb/tb_vector_gather.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vector_gather                                             |
// | Description : Self-checking bench for vector_gather (N=4 and N=1).         |
// |               Stimulus pushes hand-computed vectors into queues; a         |
// |               monitor pops and compares on every output transfer.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_vector_gather;

  localparam int N = 4;
  localparam int W = 32;
`ifdef VECTOR_GATHER_DBUF_EN
  localparam logic DBUF = 1'b1;
`else
  localparam logic DBUF = 1'b0;
`endif

  localparam logic [3:0][31:0] V1A = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
  localparam logic [3:0][31:0] V1B = {32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000};
  localparam logic [3:0][31:0] V2A = {32'h41400000, 32'h41300000, 32'h41200000, 32'h41100000};
  localparam logic [3:0][31:0] V2B = {32'h41800000, 32'h41700000, 32'h41600000, 32'h41500000};
  localparam logic [3:0][31:0] V3A = {32'h420C0000, 32'h42080000, 32'h42040000, 32'h42000000};
  localparam logic [3:0][31:0] V3B = {32'h421C0000, 32'h42180000, 32'h42140000, 32'h42100000};
  localparam logic [3:0][31:0] V4A = {32'h3FC00000, 32'h3F400000, 32'h3F000000, 32'h3E800000};
  localparam logic [3:0][31:0] V4B = {32'h40700000, 32'h40500000, 32'h40300000, 32'h40100000};
`ifdef VECTOR_GATHER_DBUF_EN
  localparam logic [3:0][31:0] V5A = {32'h45000003, 32'h45000002, 32'h45000001, 32'h45000000};
  localparam logic [3:0][31:0] V5B = {32'h46000003, 32'h46000002, 32'h46000001, 32'h46000000};
  localparam logic [3:0][31:0] V6A = {32'h47000003, 32'h47000002, 32'h47000001, 32'h47000000};
  localparam logic [3:0][31:0] V6B = {32'h48000003, 32'h48000002, 32'h48000001, 32'h48000000};
  localparam logic [3:0][31:0] V7A = {32'h49000003, 32'h49000002, 32'h49000001, 32'h49000000};
  localparam logic [3:0][31:0] V7B = {32'h4A000003, 32'h4A000002, 32'h4A000001, 32'h4A000000};
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [W-1:0]   input_a, input_b;
  logic           input_stb, input_ack;
  logic [N*W-1:0] output_v1, output_v2;
  logic           output_v1_stb, output_v2_stb, output_v1_ack, output_v2_ack;

  logic [W-1:0]   n1_a, n1_b;
  logic           n1_stb, n1_ack;
  logic [W-1:0]   n1_v1, n1_v2;
  logic           n1_v1_stb, n1_v2_stb, n1_v1_ack, n1_v2_ack;

  vector_gather #(.N(N), .W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .input_a       (input_a),
    .input_b       (input_b),
    .input_stb     (input_stb),
    .input_ack     (input_ack),
    .output_v1     (output_v1),
    .output_v2     (output_v2),
    .output_v1_stb (output_v1_stb),
    .output_v2_stb (output_v2_stb),
    .output_v1_ack (output_v1_ack),
    .output_v2_ack (output_v2_ack)
  );

  vector_gather #(.N(1), .W(W)) dut1 (
    .clk           (clk),
    .rst           (rst),
    .input_a       (n1_a),
    .input_b       (n1_b),
    .input_stb     (n1_stb),
    .input_ack     (n1_ack),
    .output_v1     (n1_v1),
    .output_v2     (n1_v2),
    .output_v1_stb (n1_v1_stb),
    .output_v2_stb (n1_v2_stb),
    .output_v1_ack (n1_v1_ack),
    .output_v2_ack (n1_v2_ack)
  );

  int total = 0;
  int bad   = 0;
  logic [127:0] q_v1 [$];
  logic [127:0] q_v2 [$];
  logic [127:0] q1_v1 [$];
  logic [127:0] q1_v2 [$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Pops one expected vector from the given queue on each output transfer.
  task automatic mon_pop(input string nm, inout logic [127:0] q [$], input logic [127:0] act);
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s unexpected vector: got %h required none", nm, act);
    end else begin
      chk(nm, act, q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (output_v1_stb && output_v1_ack) mon_pop("v1 data", q_v1, output_v1);
      if (output_v2_stb && output_v2_ack) mon_pop("v2 data", q_v2, output_v2);
      if (n1_v1_stb && n1_v1_ack) mon_pop("n1 v1 data", q1_v1, 128'(n1_v1));
      if (n1_v2_stb && n1_v2_ack) mon_pop("n1 v2 data", q1_v2, 128'(n1_v2));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required end of test");
    $fatal(1, "watchdog");
  end

  // Holds one pair on the input until it is accepted; returns 1 ns after the
  // accepting edge.
  task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    input_a   = a;
    input_b   = b;
    input_stb = 1'b1;
    while (1) begin
      @(negedge clk);
      if (input_ack) break;
      n++;
      if (n > 50) begin
        total++;
        bad++;
        $display("FAIL send_pair timeout: input_ack 0 required 1");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input logic [3:0][31:0] va, input logic [3:0][31:0] vb);
    q_v1.push_back(va);
    q_v2.push_back(vb);
    for (int k = 0; k < 4; k++) send_pair(va[k], vb[k]);
    input_stb = 1'b0;
  endtask

  task automatic chk_state(input string nm, input logic [1:0] stbs, input logic ack);
    chk({nm, " stbs"}, 128'({output_v1_stb, output_v2_stb}), 128'(stbs));
    chk({nm, " input_ack"}, 128'(input_ack), 128'(ack));
  endtask

  initial begin
    input_a = '0; input_b = '0; input_stb = 1'b0;
    output_v1_ack = 1'b1; output_v2_ack = 1'b1;
    n1_a = '0; n1_b = '0; n1_stb = 1'b0;
    n1_v1_ack = 1'b1; n1_v2_ack = 1'b1;
    rst = 1'b0;

    // Reset state and input_ack rising on the first edge after release.
    @(negedge clk);
    chk_state("reset", 2'b00, 1'b0);
    chk("reset v1", output_v1, '0);
    chk("reset v2", output_v2, '0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("ack before first edge", 128'(input_ack), 128'd0);
    @(negedge clk);
    chk("ack after first edge", 128'(input_ack), 128'd1);

    // Basic fill with both consumers always acking.
    @(posedge clk); #1;
    send_vec(V1A, V1B);
    @(negedge clk); chk_state("t1 present", 2'b11, DBUF);
    @(negedge clk); chk_state("t1 released", 2'b00, 1'b1);

    // Split acks: v1 taken at once, v2 taken 3 cycles later.
    output_v2_ack = 1'b0;
    @(posedge clk); #1;
    send_vec(V2A, V2B);
    @(negedge clk); chk_state("t2 c1", 2'b11, DBUF);
    @(negedge clk); chk_state("t2 c2", 2'b01, DBUF);
    @(negedge clk); chk_state("t2 c3", 2'b01, DBUF);
    @(posedge clk); #1 output_v2_ack = 1'b1;
    @(negedge clk); chk_state("t2 c4", 2'b01, DBUF);
    @(negedge clk); chk_state("t2 c5", 2'b00, 1'b1);

    // Reset after two pairs; the partial vector must be discarded.
    @(posedge clk); #1;
    send_pair(32'hBF800000, 32'hC0400000);
    send_pair(32'hC0000000, 32'hC0800000);
    input_stb = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk_state("t3 in reset", 2'b00, 1'b0);
    chk("t3 reset v1", output_v1, '0);
    chk("t3 reset v2", output_v2, '0);
    @(posedge clk); #1 rst = 1'b1;
    send_vec(V3A, V3B);
    @(negedge clk); chk_state("t3 present", 2'b11, DBUF);
    @(negedge clk); chk_state("t3 released", 2'b00, 1'b1);

    // Input stalled for 5 cycles between pairs 2 and 3.
    @(posedge clk); #1;
    q_v1.push_back(V4A);
    q_v2.push_back(V4B);
    send_pair(V4A[0], V4B[0]);
    send_pair(V4A[1], V4B[1]);
    input_stb = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk_state("t4 stall", 2'b00, 1'b1);
`ifndef VECTOR_GATHER_DBUF_EN
      chk("t4 lanes 0..1 v1", 128'(output_v1[63:0]), 128'({V4A[1], V4A[0]}));
      chk("t4 lanes 0..1 v2", 128'(output_v2[63:0]), 128'({V4B[1], V4B[0]}));
`endif
    end
    @(posedge clk); #1;
    send_pair(V4A[2], V4B[2]);
    send_pair(V4A[3], V4B[3]);
    input_stb = 1'b0;
    @(negedge clk); chk_state("t4 present", 2'b11, DBUF);
    @(negedge clk); chk_state("t4 released", 2'b00, 1'b1);

    // N=1: every transfer completes a vector.
    @(posedge clk); #1;
    q1_v1.push_back(128'h40000000);
    q1_v2.push_back(128'h40E00000);
    n1_a = 32'h40000000; n1_b = 32'h40E00000; n1_stb = 1'b1;
    @(negedge clk);
    chk("n1 ack before", 128'(n1_ack), 128'd1);
    @(posedge clk); #1 n1_stb = 1'b0;
    @(negedge clk);
    chk("n1 stbs after", 128'({n1_v1_stb, n1_v2_stb}), 128'd3);
    chk("n1 ack during present", 128'(n1_ack), 128'(DBUF));
    @(negedge clk);
    chk("n1 stbs released", 128'({n1_v1_stb, n1_v2_stb}), 128'd0);
    chk("n1 ack after", 128'(n1_ack), 128'd1);

`ifdef VECTOR_GATHER_DBUF_EN
    // Consumers stall after vector 5: exactly one more vector is accepted.
    begin
      int acc = 0;
      output_v1_ack = 1'b0;
      output_v2_ack = 1'b0;
      @(posedge clk); #1;
      send_vec(V5A, V5B);
      q_v1.push_back(V6A); q_v2.push_back(V6B);
      q_v1.push_back(V7A); q_v2.push_back(V7B);
      input_a = V6A[0]; input_b = V6B[0]; input_stb = 1'b1;
      repeat (9) begin
        @(negedge clk);
        if (input_stb && input_ack) acc++;
        @(posedge clk); #1;
        if (acc < 4) begin
          input_a = V6A[acc]; input_b = V6B[acc];
        end else begin
          input_a = V7A[0]; input_b = V7B[0];
        end
      end
      @(negedge clk);
      chk("t6 pairs accepted while stalled", 128'(acc), 128'd4);
      chk_state("t6 stalled", 2'b11, 1'b0);
      chk("t6 v1 held", output_v1, 128'(V5A));
      @(posedge clk); #1;
      output_v1_ack = 1'b1;
      output_v2_ack = 1'b1;
      @(negedge clk);
      chk("t6 v1 before swap", output_v1, 128'(V5A));
      @(negedge clk);
      chk_state("t6 after swap", 2'b11, 1'b1);
      chk("t6 v2 after swap", output_v2, 128'(V6B));
      @(posedge clk); #1;
      send_pair(V7A[1], V7B[1]);
      send_pair(V7A[2], V7B[2]);
      send_pair(V7A[3], V7B[3]);
      input_stb = 1'b0;
      @(negedge clk); chk_state("t6 v7 present", 2'b11, 1'b1);
    end
`endif

    repeat (2) @(negedge clk);
    chk("v1 queue drained", 128'(q_v1.size()), 128'd0);
    chk("v2 queue drained", 128'(q_v2.size()), 128'd0);
    chk("n1 v1 queue drained", 128'(q1_v1.size()), 128'd0);
    chk("n1 v2 queue drained", 128'(q1_v2.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_vector_gather
`default_nettype wire

// File: doc/vector_gather.md
# vector_gather

Upstream feeder for `inner_product`. It accepts a scalar stream of float32 element pairs (a, b) over a stb/ack handshake and assembles N pairs into two packed N-element vectors. It presents them on `output_v1`/`output_v2`, each with its own stb/ack, matching the `inner_product` input ports one-to-one. The block performs no arithmetic: it is pure deserialisation, buffering and handshaking.

## Interface
- `N`, default 4: vector length in elements, ≥1.
- `W`, default 32: element width in bits (IEEE-754 single).
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `input_a`  in  W: element for v1.
- `input_b`  in  W: element for v2.
- `input_stb`  in  1: pair valid.
- `input_ack`  out  1: pair accepted this cycle when high together with `input_stb`.
- `output_v1`  out  N×W: packed vector, lane k = bits [W·k+W-1 : W·k].
- `output_v2`  out  N×W: packed vector, same lane layout.
- `output_v1_stb`  out  1: v1 valid.
- `output_v2_stb`  out  1: v2 valid.
- `output_v1_ack`  in  1: consumer took v1.
- `output_v2_ack`  in  1: consumer took v2.

## Operation
- **Transfer rule:** a transfer occurs at a rising edge where stb and ack are both high.
- **Lane order:** the k-th accepted pair (0-based, since the last vector release or reset) is written to lane k of both vectors.
- **States:**
  - FILL: `input_ack` high and element counter `idx` in 0..N-1.
  - PRESENT: `input_ack` low; `output_v1_stb` and `output_v2_stb` are held independently.
- **FILL → PRESENT:** on the transfer with `idx == N-1`. `idx` wraps to 0 and both stbs are set.
- **Per-vector release:** `output_v1_stb` clears on the edge where `output_v1_stb && output_v1_ack`. The same applies to v2, independently.
- **PRESENT → FILL:** when both stbs are clear. Simultaneous acks on one edge clear both stbs and return to FILL on that edge.
- **Data stability:** output data is stable while either stb is high. Lanes are overwritten only during FILL.
- **N=1:** every transfer goes directly FILL → PRESENT.
- **Reset:** async assertion at any time, including mid-fill or mid-present:
  - state ← FILL, `idx` ← 0;
  - all outputs ← 0, including `input_ack` and both stbs;
  - the partial vector is discarded.
- **After reset release:** `input_ack` rises at the first clock edge.

## Timing
- `input_ack`, both stbs and vector data are registered. No combinational path from any input to any output.
- **Fill latency:** last pair transferred at edge c → both stbs high after edge c, lanes valid in the same cycle.
- **Ack response:** stb falls after the ack edge.
- **Input re-open:** `input_ack` is high again after the edge where the last outstanding vector ack is taken.
- **Throughput (single buffer):** N+1 cycles per vector with an always-acking consumer.
- **Ack ignored:** an ack while the matching stb is low has no effect.

## Configuration
- **`VECTOR_GATHER_DBUF_EN` defined:** two banks (fill bank, present bank).
  - FILL continues into the free bank while the other is presented.
  - When the fill bank completes, it swaps to present on the same edge if the present bank is empty (both stbs clear, or clearing on that edge). Otherwise `input_ack` drops until the swap.
  - Steady-state throughput: one vector per N cycles.
  - Reset clears both banks.
- **Undefined:** single bank, behaviour as above.

## Structure
- `linalg_pkg` holds:
  - `float_t` (logic [31:0]);
  - the FILL/PRESENT state enum;
  - the `FLOAT_ZERO` constant, shared with `inner_product` and later linalg blocks.
- **Sub-module `vector_bank`:** one N-lane pair register, write-lane counter and full flag. It is instantiated once, or twice under `VECTOR_GATHER_DBUF_EN`. The top level holds the handshake FSM and bank select.

## Test plan
- **Basic fill, N=4, both acks tied high:**
  - feed (3F800000,40A00000), (40000000,40C00000), (40400000,40E00000), (40800000,41000000) on consecutive cycles;
  - required: `output_v1` lanes 0..3 = 3F800000, 40000000, 40400000, 40800000 and `output_v2` lanes = 40A00000..41000000;
  - both stbs high for exactly 1 cycle after the 4th transfer; `input_ack` low for exactly that cycle.
- **Split acks:**
  - `output_v1_ack` high immediately, `output_v2_ack` delayed 3 cycles;
  - required: v1_stb falls after 1 cycle; v2_stb stays high 4 cycles; `input_ack` stays low until v2_stb clears, then rises.
- **Reset mid-fill:**
  - pulse `rst` low after 2 transfers, then feed 4 new pairs;
  - required: outputs are 0 during reset; the vector contains only the 4 new pairs, in lanes 0..3.
- **N=1:**
  - feed (40000000, 40E00000);
  - required: stbs rise after the single transfer; `input_ack` toggles 1,0,1 with an always-acking consumer.
- **Stalled input:**
  - `input_stb` low for 5 cycles between pairs 2 and 3;
  - required: `idx` holds; lanes 0..1 are unchanged; final vector is correct.
- **`VECTOR_GATHER_DBUF_EN`:**
  - both output acks held low for 10 cycles after the first vector;
  - required: exactly 4 further pairs are accepted, then `input_ack` falls;
  - releasing the acks presents vector 2 on the next edge, with vector 1 data unchanged until that edge.
